// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO.
package sync_fifo_pkg;
`include "sync_fifo_defs.vh"

  localparam int MODE_STD  = `FIFO_MODE_STD;
  localparam int MODE_FWFT = `FIFO_MODE_FWFT;

  // State of the RAM output register that drives data_out.
  // Standard mode: OS_FULL marks the one-cycle rd_valid strobe.
  // FWFT mode: OS_FULL means data_out holds the head word.
  typedef enum logic {
    OS_EMPTY = 1'b0,
    OS_FULL  = 1'b1
  } out_state_e;

  // Sticky error bit update: a new error in the same cycle as a clear wins.
  function automatic logic sticky_next(input logic cur, input logic clr, input logic set);
    return (cur && !clr) || set;
  endfunction

endpackage

// File: rtl/dpram_1clk.sv
// Single-clock simple dual-port RAM with registered, enabled read port.
// A read of the address being written in the same cycle returns the old word.
module dpram_1clk #(
  parameter int ASZ = 10,
  parameter int DSZ = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [ASZ-1:0] waddr,
  input  logic [DSZ-1:0] wdata,
  input  logic           re,
  input  logic [ASZ-1:0] raddr,
  output logic [DSZ-1:0] rdata
);

  logic [DSZ-1:0] mem_q [(1 << ASZ)];
  logic [DSZ-1:0] rdata_q;
  logic [DSZ-1:0] rdata_d;

  // Storage array: write port only, contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register keeps its value while re is low.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // Read data register; cleared by reset so the FIFO output starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_defs.vh
// Read-mode encodings for the FWFT parameter of sync_fifo.
`ifndef SYNC_FIFO_DEFS_VH
`define SYNC_FIFO_DEFS_VH
`define FIFO_MODE_STD  0
`define FIFO_MODE_FWFT 1
`endif

// File: rtl/sync_fifo.sv
// Single-clock FIFO around dpram_1clk with level, full/empty, almost flags
// and sticky overflow/underflow. FWFT=1 turns the RAM read register into a
// prefetched output stage that always shows the head word when not empty.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int ASZ        = 10,
  parameter int DSZ        = 16,
  parameter int FWFT       = MODE_STD,
  parameter int AFULL_THR  = (1 << ASZ) - 4,
  parameter int AEMPTY_THR = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [DSZ-1:0] data_in,
  input  logic           rd_en,
  output logic [DSZ-1:0] data_out,
  output logic           rd_valid,
  output logic [ASZ:0]   level,
  output logic           full,
  output logic           empty,
  output logic           almost_full,
  output logic           almost_empty,
  output logic           overflow,
  output logic           underflow,
  input  logic           clr_err
);

  localparam bit           IS_FWFT  = (FWFT == MODE_FWFT);
  localparam logic [ASZ:0] DEPTH_L  = {1'b1, {ASZ{1'b0}}};
  localparam logic [ASZ:0] AFULL_L  = (ASZ+1)'(AFULL_THR);
  localparam logic [ASZ:0] AEMPTY_L = (ASZ+1)'(AEMPTY_THR);
  localparam logic [ASZ:0] LVL_ONE  = (ASZ+1)'(1);

  out_state_e     state_q, state_d;
  logic [ASZ-1:0] wr_ptr_q, wr_ptr_d;
  logic [ASZ-1:0] rd_ptr_q, rd_ptr_d;
  logic [ASZ:0]   level_q, level_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic           afull_q, afull_d;
  logic           aempty_q, aempty_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  logic           wr_acc;
  logic           rd_acc;
  logic           ram_has;
  logic           fetch;

  // Accept/fetch decisions, next-state of the output stage, counters and flags.
  always_comb begin
    wr_acc  = wr_en && !full_q;
    rd_acc  = rd_en && !empty_q;
    // Words still sitting in the RAM array (in FWFT the output stage holds one more).
    ram_has = level_q > (ASZ+1)'(state_q == OS_FULL);
    // FWFT refills the output stage when it is empty or being popped; the word
    // written on this same edge is never needed, so no bypass is required.
    if (IS_FWFT) fetch = ram_has && ((state_q == OS_EMPTY) || rd_acc);
    else         fetch = rd_acc;

    state_d = OS_EMPTY;
    if (fetch)                  state_d = OS_FULL;
    else if (IS_FWFT && !rd_acc) state_d = state_q;

    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    wr_ptr_d = wr_ptr_q + ASZ'(wr_acc);
    rd_ptr_d = rd_ptr_q + ASZ'(fetch);

    full_d   = (level_d == DEPTH_L);
    if (IS_FWFT) empty_d = (state_d == OS_EMPTY);
    else         empty_d = (level_d == '0);
    afull_d  = (level_d >= AFULL_L);
    aempty_d = (level_d <= AEMPTY_L);

    ovf_d = sticky_next(ovf_q, clr_err, wr_en && full_q);
    unf_d = sticky_next(unf_q, clr_err, rd_en && empty_q);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OS_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  dpram_1clk #(
    .ASZ (ASZ),
    .DSZ (DSZ)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (fetch),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  assign rd_valid     = IS_FWFT ? !empty_q : (state_q == OS_FULL);
  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
